// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, line levels and baud divisor helper shared by
// the UART transmit and receive paths.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic LINE_IDLE   = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   // Clocks per bit; integer division, so the line rate is rounded up.
   function automatic int calc_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// uart_tx_baud_gen: free-running 0..DIV-1 bit-period counter with a tick on
// the last clock of each bit; clear restarts the period from zero.
module uart_tx_baud_gen #(
   parameter int DIV = 16
)(
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic baud_tick
);

   localparam int                CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable) begin
         if (r_cnt == LAST) r_cnt <= '0;
         else               r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign baud_tick = enable && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises one byte per valid/ready handshake as start, LSB-first
// data and stop bits. Define UART_TX_PARITY_EN to insert an even parity bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 115200,
   parameter int DATA_BITS = 8
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 tx_busy,
   output logic                 tx_done,
   output uart_state_e          dbg_state
);

   localparam int         DIV      = calc_div(CLK_FREQ, BAUD_RATE);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   // Handshake: tx_ready is high only in IDLE; a byte is taken on any rising
   // edge where tx_valid && tx_ready. tx_valid/tx_data are ignored otherwise.

   uart_state_e          r_state;
   uart_state_e          w_state_next;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_next;
   logic [2:0]           r_idx;
   logic [2:0]           w_idx_next;
   logic                 r_txd;
   logic                 w_txd_next;
   logic                 w_accept;
   logic                 w_tick;
   logic                 w_done;
`ifdef UART_TX_PARITY_EN
   logic                 r_parity;
`endif

   uart_tx_baud_gen #(
      .DIV (DIV)
   ) u_baud_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (tx_busy),
      .clear     (w_accept),
      .baud_tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_idx   <= '0;
         r_txd   <= LINE_IDLE;
      end else begin
         r_state <= w_state_next;
         r_shift <= w_shift_next;
         r_idx   <= w_idx_next;
         r_txd   <= w_txd_next;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst_n)        r_parity <= 1'b0;
      else if (w_accept) r_parity <= ^tx_data;
   end
`endif

   always_comb begin
      w_state_next = r_state;
      w_shift_next = r_shift;
      w_idx_next   = r_idx;
      w_accept     = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (tx_valid) begin
               w_accept     = 1'b1;
               w_shift_next = tx_data;
               w_state_next = START;
            end
         end
         START: begin
            if (w_tick) begin
               w_state_next = DATA;
               w_idx_next   = '0;
            end
         end
         DATA: begin
            if (w_tick) begin
               w_shift_next = r_shift >> 1;
               // Index parks at 0 after the last bit so it never wraps.
               if (r_idx == LAST_BIT) begin
                  w_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                  w_state_next = PARITY;
`else
                  w_state_next = STOP;
`endif
               end else begin
                  w_idx_next = r_idx + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (w_tick) w_state_next = STOP;
         end
`endif
         STOP: begin
            if (w_tick) begin
               w_done       = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // txd is registered from the next state so the pin never glitches.
   always_comb begin
      w_txd_next = LINE_IDLE;
      case (w_state_next)
         START:   w_txd_next = START_LEVEL;
         DATA:    w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  w_txd_next = r_parity;
`endif
         STOP:    w_txd_next = STOP_LEVEL;
         default: w_txd_next = LINE_IDLE;
      endcase
   end

   assign txd       = r_txd;
   assign tx_ready  = (r_state == IDLE);
   assign tx_busy   = (r_state != IDLE);
   assign tx_done   = w_done;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized frames checked bit-by-bit against a
// frame model built from the serial format rules.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int CLK_FREQ  = 16;
   localparam int BAUD_RATE = 1;
   localparam int DATA_BITS = 8;
   localparam int DIV       = 16;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NBITS = 1 + DATA_BITS + P + 1;
   localparam int FL    = NBITS * DIV;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [DATA_BITS-1:0] tx_data = '0;
   logic                 tx_valid = 1'b0;
   logic                 tx_ready;
   logic                 txd;
   logic                 tx_busy;
   logic                 tx_done;
   uart_state_e          dbg_state;

   int vectors = 0;
   int miscompares = 0;

   uart_tx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .DATA_BITS (DATA_BITS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .txd       (txd),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame model: list of line levels, one entry per bit period.
   function automatic logic exp_bit(input logic [DATA_BITS-1:0] d, input int k);
      logic frame[$];
      frame.push_back(1'b0);
      for (int i = 0; i < DATA_BITS; i++) frame.push_back(d[i]);
      if (P == 1) begin
         int ones = 0;
         for (int i = 0; i < DATA_BITS; i++) ones += int'(d[i]);
         frame.push_back(ones % 2 == 1);
      end
      frame.push_back(1'b1);
      return frame[k];
   endfunction

   // Called in an IDLE cycle; handshake happens at the next edge.
   task automatic start_frame(input logic [DATA_BITS-1:0] d);
      check("ready_before_send", {31'd0, tx_ready}, 32'd1);
      tx_data  = d;
      tx_valid = 1'b1;
      tick();
   endtask

   // Checks cycles [first, last] of a frame already started. hold keeps
   // tx_valid high; scramble randomizes inputs while busy.
   task automatic check_frame(input logic [DATA_BITS-1:0] d, input int first, input int last,
                              input bit hold, input bit scramble);
      for (int n = first; n <= last; n++) begin
         check("txd_bit", {31'd0, txd}, {31'd0, exp_bit(d, n / DIV)});
         check("tx_done", {31'd0, tx_done}, {31'd0, (n == FL - 1)});
         if (n == 0 || n == FL - 1) begin
            check("ready_busy", {30'd0, tx_ready, tx_busy}, 32'd1);
         end
         if (scramble) tx_data = DATA_BITS'($urandom);
         if (!hold) tx_valid = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
         if (!hold && n == FL - 1) tx_valid = 1'b0;
         tick();
      end
   endtask

   task automatic check_idle(input string tag);
      check(tag, {28'd0, txd, tx_ready, tx_busy, tx_done}, 32'b1100);
   endtask

   initial begin
      logic [DATA_BITS-1:0] rb;

      // Reset values.
      tick();
      tick();
      check_idle("reset_outputs");
      check("reset_state", {29'd0, dbg_state}, {29'd0, IDLE});
      rst_n = 1'b1;

      // Idle line for 100 clocks with tx_valid low.
      for (int i = 0; i < 100; i++) begin
         tick();
         check_idle("idle_100");
      end

      // 0xA5: txd falls the cycle after handshake, done on clock 160.
      start_frame(8'hA5);
      tx_valid = 1'b0;
      check_frame(8'hA5, 0, FL - 1, 1'b0, 1'b0);
      check_idle("after_a5");

      // Back-to-back with tx_valid held: one idle cycle between frames.
      start_frame(8'h00);
      check_frame(8'h00, 0, FL - 1, 1'b1, 1'b1);
      check_idle("b2b_gap");
      tx_data = 8'hFF;
      tick();
      tx_valid = 1'b0;
      check_frame(8'hFF, 0, FL - 1, 1'b0, 1'b1);
      check_idle("after_ff");

      // Reset during data bit 3 of 0x3C.
      start_frame(8'h3C);
      tx_valid = 1'b0;
      check_frame(8'h3C, 0, 4 * DIV + 5, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_idle("reset_midframe");
      check("reset_mid_state", {29'd0, dbg_state}, {29'd0, IDLE});
      for (int i = 0; i < 2 * DIV; i++) begin
         check_idle("post_abort_idle");
         tick();
      end
      start_frame(8'h55);
      tx_valid = 1'b0;
      check_frame(8'h55, 0, FL - 1, 1'b0, 1'b0);
      check_idle("after_55");

`ifdef UART_TX_PARITY_EN
      start_frame(8'h07);
      tx_valid = 1'b0;
      check("parity_07", {31'd0, exp_bit(8'h07, 1 + DATA_BITS)}, 32'd1);
      check_frame(8'h07, 0, FL - 1, 1'b0, 1'b0);
      start_frame(8'h03);
      tx_valid = 1'b0;
      check("parity_03", {31'd0, exp_bit(8'h03, 1 + DATA_BITS)}, 32'd0);
      check_frame(8'h03, 0, FL - 1, 1'b0, 1'b0);
      check_idle("after_parity");
`endif

      // Random bytes with noisy inputs while busy.
      for (int f = 0; f < 4; f++) begin
         rb = DATA_BITS'($urandom);
         start_frame(rb);
         tx_valid = 1'b0;
         check_frame(rb, 0, FL - 1, 1'b0, 1'b1);
         check_idle("after_random");
      end

      // tx_valid raised on the done cycle: accepted only from IDLE.
      rb = DATA_BITS'($urandom);
      start_frame(rb);
      tx_valid = 1'b0;
      check_frame(rb, 0, FL - 2, 1'b0, 1'b0);
      check("done_cycle", {31'd0, tx_done}, 32'd1);
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      tick();
      check_idle("not_taken_on_done");
      tick();
      tx_valid = 1'b0;
      check("start_2_after_done", {30'd0, txd, tx_busy}, 32'b01);
      check_frame(8'hC3, 0, FL - 1, 1'b0, 1'b0);
      check_idle("final_idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
